// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C widths, FSM state encodings and a 3-sample majority helper,
// used by both i2c_peripheral and i2c_controller.
package i2c_pkg;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] ST_RX_DATA  = 4'd3;
    localparam logic [3:0] ST_RX_ACK   = 4'd4;
    localparam logic [3:0] ST_TX_DATA  = 4'd5;
    localparam logic [3:0] ST_TX_ACK   = 4'd6;
    localparam logic [3:0] ST_IGNORE   = 4'd7;
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction
endpackage

// File: rtl/i2c_line_sampler.sv
// i2c_line_sampler: conditions sdc/sda and detects clock edges, START and STOP.
// Define I2C_GLITCH_FILTER_EN to add a 2-flop synchronizer plus 3-sample majority filter.
module i2c_line_sampler
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sdc_i,
    input  logic sda_i,
    output logic sda_o,
    output logic rise_o,
    output logic fall_o,
    output logic start_o,
    output logic stop_o
);
    logic [1:0] ln_d, lv_q, pv_q;
`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] s1_q, s2_q;
    logic [2:0] h_scl_q, h_sda_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '1;
            s2_q    <= '1;
            h_scl_q <= '1;
            h_sda_q <= '1;
        end else begin
            s1_q    <= {sdc_i, sda_i};
            s2_q    <= s1_q;
            h_scl_q <= {h_scl_q[1:0], s2_q[1]};
            h_sda_q <= {h_sda_q[1:0], s2_q[0]};
        end
    end
    assign ln_d = {maj3(h_scl_q), maj3(h_sda_q)};
`else
    assign ln_d = {sdc_i, sda_i};
`endif
    // lv_q is the conditioned level, pv_q its previous value for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            lv_q <= '1;
            pv_q <= '1;
        end else begin
            lv_q <= ln_d;
            pv_q <= lv_q;
        end
    end
    assign sda_o   = lv_q[0];
    assign rise_o  = lv_q[1] & ~pv_q[1];
    assign fall_o  = ~lv_q[1] & pv_q[1];
    assign start_o = lv_q[1] & pv_q[1] & pv_q[0] & ~lv_q[0];
    assign stop_o  = lv_q[1] & pv_q[1] & ~pv_q[0] & lv_q[0];
endmodule

// File: rtl/i2c_peripheral.sv
// i2c_peripheral: I2C target FSM answering at PERIPH_ADDR; line conditioning lives in
// i2c_line_sampler (glitch filter enabled by I2C_GLITCH_FILTER_EN).
module i2c_peripheral
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PERIPH_ADDR = 7'h03
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sdc,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic [DATA_W-1:0] tx_byte,
    output logic              tx_req,
    output logic [DATA_W-1:0] rx_byte,
    output logic              rx_valid,
    output logic [3:0]        state
);
    logic              sda, rise, fall, start, stop, load;
    logic [3:0]        state_q, state_d, cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d, rx_byte_q, rx_byte_d, sh;
    logic              rw_q, rw_d, oe_q, oe_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;

    i2c_line_sampler u_sampler (
        .clk     (clk),
        .reset   (reset),
        .sdc_i   (sdc),
        .sda_i   (sda_in),
        .sda_o   (sda),
        .rise_o  (rise),
        .fall_o  (fall),
        .start_o (start),
        .stop_o  (stop)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        rw_d       = rw_q;
        oe_d       = oe_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        load       = 1'b0;
        sh         = {sr_q[DATA_W-2:0], sda};
        if (stop) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            cnt_d   = '0;
        end else if (start) begin
            state_d = ST_ADDR;
            oe_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_IGNORE: ;
                ST_ADDR: if (rise) begin
                    sr_d  = sh;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rw_d    = sda;
                        cnt_d   = '0;
                        state_d = (sr_q[ADDR_W-1:0] == PERIPH_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                    end
                end
                // first fall pulls SDA for the ACK clock, the second releases it
                ST_ADDR_ACK, ST_RX_ACK: if (fall) begin
                    if (cnt_q == 4'd0) begin
                        oe_d  = 1'b1;
                        cnt_d = 4'd1;
                    end else if (state_q == ST_RX_ACK || !rw_q) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_RX_DATA;
                    end else begin
                        load = 1'b1;
                    end
                end
                ST_RX_DATA: if (rise) begin
                    sr_d  = sh;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rx_byte_d  = sh;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_RX_ACK;
                    end
                end
                ST_TX_DATA: if (fall) begin
                    if (cnt_q == 4'd8) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_TX_ACK;
                    end else begin
                        oe_d  = ~sr_q[DATA_W-1];
                        sr_d  = {sr_q[DATA_W-2:0], 1'b0};
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_TX_ACK: if (rise) begin
                    state_d = sda ? ST_IGNORE : state_q;
                    cnt_d   = 4'd1;
                end else if (fall && cnt_q == 4'd1) begin
                    load = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
        // the fall that enters TX_DATA also drives the first (MSB) data bit
        if (load) begin
            tx_req_d = 1'b1;
            oe_d     = ~tx_byte[DATA_W-1];
            sr_d     = {tx_byte[DATA_W-2:0], 1'b0};
            cnt_d    = 4'd1;
            state_d  = ST_TX_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
        end
    end

    assign sda_oe   = oe_q;
    assign tx_req   = tx_req_q;
    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;
    assign state    = state_q;
endmodule

// File: tb/tb_i2c_peripheral.sv
// tb_i2c_peripheral: bus-level controller model with scoreboard queues for line levels,
// received bytes and transmit requests.
module tb_i2c_peripheral;
    localparam int Q = 8;
    localparam logic [6:0] PA = 7'h03;

    logic       clk, reset, sdc, sda_o, sda_in, sda_oe, tx_req, rx_valid;
    logic [7:0] tx_byte, rx_byte;
    logic [3:0] state;
    logic [7:0] dat [4];
    logic [1:0] bit_q [$];
    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];
    int         chk = 0, errs = 0, gl = -1, oe_hi = 0, viol = 0, n0;
    logic       oe_prev = 1'b0;
    event       mid_high;

    assign sda_in = sda_o & ~sda_oe;

    i2c_peripheral #(.PERIPH_ADDR(PA)) dut (
        .clk(clk), .reset(reset), .sdc(sdc), .sda_in(sda_in), .sda_oe(sda_oe),
        .tx_byte(tx_byte), .tx_req(tx_req), .rx_byte(rx_byte), .rx_valid(rx_valid), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        chk++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] ctl(input logic b);
        return {b, 1'b0};
    endfunction

    function automatic logic [1:0] per(input logic b);
        return {b, ~b};
    endfunction

    // expected {line level, sda_oe} is queued as each SCL pulse is issued
    task automatic clk_bit(input logic drv, input logic [1:0] e, input logic g);
        bit_q.push_back(e);
        w(Q); sda_o = drv; w(Q); sdc = 1'b1;
        if (g) begin
            w(2); sdc = 1'b0; w(1); sdc = 1'b1; w(Q - 3);
        end else w(Q);
        -> mid_high;
        w(Q); sdc = 1'b0;
    endtask

    task automatic do_start();
        if (!sdc) begin
            sda_o = 1'b1; w(Q); sdc = 1'b1;
        end
        w(Q); sda_o = 1'b0; w(Q); sdc = 1'b0;
    endtask

    task automatic do_stop();
        sda_o = 1'b0; w(Q); sdc = 1'b1; w(Q); sda_o = 1'b1; w(Q);
    endtask

    task automatic xact(input logic [6:0] a, input logic rw, input int n, input logic stp);
        logic       m;
        logic [7:0] ab;
        m  = (a == PA);
        ab = {a, rw};
        do_start();
        if (m && rw) begin
            tx_byte = dat[0];
            tx_q.push_back(dat[0]);
        end
        for (int i = 7; i >= 0; i--) clk_bit(ab[i], ctl(ab[i]), gl == i);
        clk_bit(1'b1, m ? per(1'b0) : ctl(1'b1), 1'b0);
        if (!rw) begin
            for (int k = 0; k < n; k++) begin
                if (m) rx_q.push_back(dat[k]);
                for (int i = 7; i >= 0; i--) clk_bit(dat[k][i], ctl(dat[k][i]), 1'b0);
                clk_bit(1'b1, m ? per(1'b0) : ctl(1'b1), 1'b0);
            end
        end else if (m) begin
            for (int k = 0; k < n; k++) begin
                for (int i = 7; i >= 0; i--) begin
                    clk_bit(1'b1, per(dat[k][i]), 1'b0);
                    if (i == 3 && k + 1 < n) tx_byte = dat[k + 1];
                end
                if (k + 1 < n) begin
                    tx_q.push_back(dat[k + 1]);
                    clk_bit(1'b0, ctl(1'b0), 1'b0);
                end else clk_bit(1'b1, ctl(1'b1), 1'b0);
            end
        end
        if (stp) do_stop();
    endtask

    always @(mid_high) begin
        check("bit_pending", bit_q.size() > 0, 1);
        if (bit_q.size() > 0) check("sda_line_oe", {sda_in, sda_oe}, bit_q.pop_front());
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            check("rx_expected", rx_q.size() > 0, 1);
            if (rx_q.size() > 0) check("rx_byte", rx_byte, rx_q.pop_front());
        end
        if (tx_req) begin
            check("tx_expected", tx_q.size() > 0, 1);
            if (tx_q.size() > 0) check("tx_byte_at_req", tx_byte, tx_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (sda_oe) oe_hi++;
        if (sda_oe !== oe_prev && sdc === 1'b1 && !reset) viol++;
        oe_prev = sda_oe;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ab;
        reset = 1'b1; sdc = 1'b1; sda_o = 1'b1; tx_byte = 8'h00;
        w(4);
        check("rst_state", state, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_byte", rx_byte, 8'h00);
        reset = 1'b0; w(4);

        dat[0] = 8'h07;
        xact(PA, 1'b0, 1, 1'b1); w(4);
        check("wr07_state", state, 0);
        check("wr07_rx_byte", rx_byte, 8'h07);

        dat[0] = 8'hA5;
        xact(PA, 1'b1, 1, 1'b0); w(4);
        check("rd_nack_state", state, 7);
        do_stop(); w(4);
        check("rd_stop_state", state, 0);

        n0 = oe_hi;
        dat[0] = 8'h5C;
        xact(7'h05, 1'b0, 1, 1'b1);
        xact(7'h05, 1'b1, 1, 1'b1);
        check("miss_oe_cycles", oe_hi - n0, 0);

        dat[0] = 8'h12;
        xact(PA, 1'b0, 1, 1'b0);
        check("rs_rx_byte", rx_byte, 8'h12);
        dat[0] = 8'h34;
        xact(PA, 1'b1, 1, 1'b1); w(4);
        check("rs_state", state, 0);

        dat[0] = 8'hC3;
        ab = {PA, 1'b0};
        do_start();
        for (int i = 7; i >= 0; i--) clk_bit(ab[i], ctl(ab[i]), 1'b0);
        clk_bit(1'b1, per(1'b0), 1'b0);
        for (int i = 7; i >= 4; i--) clk_bit(dat[0][i], ctl(dat[0][i]), 1'b0);
        reset = 1'b1; w(1);
        check("mid_rst_state", state, 0);
        check("mid_rst_oe", sda_oe, 0);
        reset = 1'b0; sda_o = 1'b1; w(2); sdc = 1'b1; w(2 * Q);
        dat[0] = 8'h3C;
        xact(PA, 1'b0, 1, 1'b1);
        check("post_rst_rx_byte", rx_byte, 8'h3C);

`ifdef I2C_GLITCH_FILTER_EN
        gl = 3;
        dat[0] = 8'h5A;
        xact(PA, 1'b0, 1, 1'b1);
        gl = -1;
        check("glitch_rx_byte", rx_byte, 8'h5A);
`endif

        for (int t = 0; t < 20; t++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : PA;
            for (int k = 0; k < 4; k++) dat[k] = 8'($urandom);
            xact(a, 1'($urandom), $urandom_range(1, 3), (t == 19) || ($urandom_range(0, 1) == 1));
        end
        w(20);
        check("final_state", state, 0);
        check("bit_q_drained", bit_q.size(), 0);
        check("rx_q_drained", rx_q.size(), 0);
        check("tx_q_drained", tx_q.size(), 0);
        check("oe_change_scl_high", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", chk, errs);
        $finish;
    end
endmodule
